uart_tx_frame: RTL and testbench

UART transmit framer and serializer, the transmit-side counterpart of the receive-side start/stop/parity checker in the UART IP core. It accepts a parallel byte with parity configuration, builds the frame and shifts it out LSB-first on the serial line: start bit, 8 data bits, optional parity bit, then 1 or 2 stop bits. Bit timing comes from an internal clocks-per-bit counter. The parity convention matches the receive checker, so a frame from this block passes with no start, stop or data error.

---
 rtl/uart_tx_frame.sv | 158 +++++++++++++++
 tb/tb_uart_tx_frame.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/uart_tx_frame.sv
// UART transmit framer/serializer: start bit, 8 data bits LSB first,
// optional parity bit, then 1 or 2 stop bits. Bit timing comes from an
// internal clocks-per-bit counter. Every output is a flop, so tx is glitch-free.
module uart_tx_frame #(
  parameter int CLKS_PER_BIT = 868,
  parameter int STOP_BITS    = 1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tx_start,
  input  logic [7:0] data_in,
  input  logic       parity_type,
  input  logic       def_en,
  output logic       tx,
  output logic       busy,
  output logic       done
);

  localparam int CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);
  // Index of the final stop bit: 0 for one stop bit, 1 for two.
  localparam logic STOP_LAST = (STOP_BITS == 2);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t           state_reg,    state_next;
  logic [CNT_W-1:0] baud_cnt_reg, baud_cnt_next;
  logic [2:0]       bit_idx_reg,  bit_idx_next;
  logic             stop_cnt_reg, stop_cnt_next;
  logic [7:0]       shift_reg,    shift_next;
  logic             par_bit_reg,  par_bit_next;
  logic             par_en_reg,   par_en_next;
  logic             tx_reg,       tx_next;
  logic             busy_reg,     busy_next;
  logic             done_reg,     done_next;

  logic bit_end;

  // The current bit period ends on the last count of the baud counter.
  assign bit_end = (baud_cnt_reg == CNT_MAX);

  // State, counters, latched frame data and registered outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= IDLE;
      baud_cnt_reg <= '0;
      bit_idx_reg  <= '0;
      stop_cnt_reg <= 1'b0;
      shift_reg    <= '0;
      par_bit_reg  <= 1'b0;
      par_en_reg   <= 1'b0;
      tx_reg       <= 1'b1;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      baud_cnt_reg <= baud_cnt_next;
      bit_idx_reg  <= bit_idx_next;
      stop_cnt_reg <= stop_cnt_next;
      shift_reg    <= shift_next;
      par_bit_reg  <= par_bit_next;
      par_en_reg   <= par_en_next;
      tx_reg       <= tx_next;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  // Next-state logic. The line level is computed from the next state so
  // that it can be registered without adding a cycle of latency.
  always_comb begin
    state_next    = state_reg;
    baud_cnt_next = baud_cnt_reg + 1'b1;
    bit_idx_next  = bit_idx_reg;
    stop_cnt_next = stop_cnt_reg;
    shift_next    = shift_reg;
    par_bit_next  = par_bit_reg;
    par_en_next   = par_en_reg;
    done_next     = 1'b0;
    tx_next       = 1'b1;

    case (state_reg)
      IDLE: begin
        baud_cnt_next = '0;
        if (tx_start) begin
          // Parity is computed once from the latched byte; odd parity is
          // the inverted XOR.
          shift_next   = data_in;
          par_bit_next = (^data_in) ^ parity_type;
          par_en_next  = def_en;
          bit_idx_next = '0;
          state_next   = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          bit_idx_next  = '0;
          state_next    = DATA;
        end
      end
      DATA: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (bit_idx_reg == 3'd7) begin
            stop_cnt_next = 1'b0;
            state_next    = par_en_reg ? PARITY : STOP;
          end else begin
            bit_idx_next = bit_idx_reg + 3'd1;
            shift_next   = {1'b0, shift_reg[7:1]};
          end
        end
      end
      PARITY: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          stop_cnt_next = 1'b0;
          state_next    = STOP;
        end
      end
      STOP: begin
        if (bit_end) begin
          baud_cnt_next = '0;
          if (stop_cnt_reg == STOP_LAST) begin
            done_next  = 1'b1;
            state_next = IDLE;
          end else begin
            stop_cnt_next = 1'b1;
          end
        end
      end
      default: begin
        baud_cnt_next = '0;
        state_next    = IDLE;
      end
    endcase

    case (state_next)
      START:   tx_next = 1'b0;
      DATA:    tx_next = shift_next[0];
      PARITY:  tx_next = par_bit_reg;
      default: tx_next = 1'b1;
    endcase

    busy_next = (state_next != IDLE);
  end

  assign tx   = tx_reg;
  assign busy = busy_reg;
  assign done = done_reg;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Randomized bench for uart_tx_frame. Two instances (one and two stop bits)
// share clock and reset; each frame is checked cycle by cycle against a
// bit list built from the framing rules.
module tb_uart_tx_frame;

  localparam int CPB = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       start_a, start_b;
  logic [7:0] din_a, din_b;
  logic       pt_a, pt_b, pe_a, pe_b;
  logic       tx_a, tx_b, busy_a, busy_b, done_a, done_b;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .tx_start(start_a), .data_in(din_a),
    .parity_type(pt_a), .def_en(pe_a), .tx(tx_a), .busy(busy_a), .done(done_a)
  );

  uart_tx_frame #(.CLKS_PER_BIT(CPB), .STOP_BITS(2)) dut_b (
    .clk(clk), .rst(rst), .tx_start(start_b), .data_in(din_b),
    .parity_type(pt_b), .def_en(pe_b), .tx(tx_b), .busy(busy_b), .done(done_b)
  );

  task automatic check_eq(input string tag, input logic got, input logic exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drive(input int sel, input logic go, input logic [7:0] d,
                       input logic pt, input logic pe);
    if (sel == 0) begin
      start_a = go; din_a = d; pt_a = pt; pe_a = pe;
    end else begin
      start_b = go; din_b = d; pt_b = pt; pe_b = pe;
    end
  endtask

  task automatic check_outputs(input int sel, input string tag, input logic etx,
                               input logic ebusy, input logic edone);
    if (sel == 0) begin
      check_eq({tag, "_a_tx"}, tx_a, etx);
      check_eq({tag, "_a_busy"}, busy_a, ebusy);
      check_eq({tag, "_a_done"}, done_a, edone);
    end else begin
      check_eq({tag, "_b_tx"}, tx_b, etx);
      check_eq({tag, "_b_busy"}, busy_b, ebusy);
      check_eq({tag, "_b_done"}, done_b, edone);
    end
  endtask

  task automatic idle(input int sel, input int cycles);
    for (int c = 0; c < cycles; c++) begin
      @(negedge clk);
      check_outputs(sel, "idle", 1'b1, 1'b0, 1'b0);
    end
  endtask

  // Entered at the negedge where the request was driven. Returns at the
  // negedge of the done cycle, where the caller may chain the next request.
  task automatic run_frame(input int sel, input logic [7:0] d, input logic pt,
                           input logic pe, input bit poke_mid);
    bit   q[$];
    int   ones;
    int   n;
    logic p;
    q.push_back(1'b0);
    for (int b = 0; b < 8; b++) q.push_back(d[b]);
    if (pe) begin
      ones = $countones(d);
      p = pt ? ((ones % 2) == 0) : ((ones % 2) == 1);
      q.push_back(p);
    end
    for (int s = 0; s < (sel == 0 ? 1 : 2); s++) q.push_back(1'b1);
    n = q.size() * CPB;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check_outputs(sel, "frame", q[i / CPB], 1'b1, 1'b0);
      // Scramble inputs after accept; the frame must not follow them.
      if (i == 0) drive(sel, 1'b0, 8'($urandom), 1'($urandom), 1'($urandom));
      if (poke_mid && i == 3 * CPB + 1) drive(sel, 1'b1, 8'h55, 1'($urandom), 1'($urandom));
      if (poke_mid && i == 3 * CPB + 2) drive(sel, 1'b0, 8'h55, 1'b0, 1'b0);
    end
    @(negedge clk);
    check_outputs(sel, "done", 1'b1, 1'b0, 1'b1);
    $display("frame inst=%0d data=%02h parity_type=%0d def_en=%0d busy_cycles=%0d",
             sel, d, pt, pe, n);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] d, nd;
    logic       pt, pe, npt, npe;
    int         sel;
    bit         chain;

    rst = 1'b1;
    drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    drive(1, 1'b0, 8'h00, 1'b0, 1'b0);
    repeat (3) @(negedge clk);
    check_outputs(0, "reset", 1'b1, 1'b0, 1'b0);
    check_outputs(1, "reset", 1'b1, 1'b0, 1'b0);
    rst = 1'b0;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      check_outputs(0, "post_reset", 1'b1, 1'b0, 1'b0);
      check_outputs(1, "post_reset", 1'b1, 1'b0, 1'b0);
    end

    // Directed frames: even, odd, no parity, two stop bits.
    drive(0, 1'b1, 8'h17, 1'b0, 1'b1); run_frame(0, 8'h17, 1'b0, 1'b1, 1'b0); idle(0, 2);
    drive(0, 1'b1, 8'h17, 1'b1, 1'b1); run_frame(0, 8'h17, 1'b1, 1'b1, 1'b0); idle(0, 2);
    drive(0, 1'b1, 8'h17, 1'b0, 1'b0); run_frame(0, 8'h17, 1'b0, 1'b0, 1'b0); idle(0, 2);
    drive(1, 1'b1, 8'hA5, 1'b0, 1'b0); run_frame(1, 8'hA5, 1'b0, 1'b0, 1'b0); idle(1, 2);

    // Mid-frame request ignored, then a request in the done cycle.
    drive(0, 1'b1, 8'h96, 1'b0, 1'b1); run_frame(0, 8'h96, 1'b0, 1'b1, 1'b1);
    drive(0, 1'b1, 8'h3C, 1'b1, 1'b1); run_frame(0, 8'h3C, 1'b1, 1'b1, 1'b0);
    idle(0, 2);

    // Randomized frames, some chained back-to-back.
    sel = int'($urandom % 2);
    d = 8'($urandom); pt = 1'($urandom); pe = 1'($urandom);
    drive(sel, 1'b1, d, pt, pe);
    for (int k = 0; k < 12; k++) begin
      run_frame(sel, d, pt, pe, (k % 3) == 0);
      if (k == 11) break;
      chain = 1'($urandom);
      nd = 8'($urandom); npt = 1'($urandom); npe = 1'($urandom);
      if (!chain) begin
        idle(sel, 1);
        sel = int'($urandom % 2);
      end
      d = nd; pt = npt; pe = npe;
      drive(sel, 1'b1, d, pt, pe);
    end
    idle(sel, 2);

    // Reset during data bit 3 (a 0 bit of 8'h17), then a fresh frame.
    drive(0, 1'b1, 8'h17, 1'b0, 1'b1);
    for (int i = 0; i < 4 * CPB + 2; i++) begin
      @(negedge clk);
      if (i == 0) drive(0, 1'b0, 8'h00, 1'b0, 1'b0);
    end
    check_eq("pre_reset_tx_low", tx_a, 1'b0);
    rst = 1'b1;
    #1;
    check_outputs(0, "async_reset", 1'b1, 1'b0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      check_outputs(0, "in_reset", 1'b1, 1'b0, 1'b0);
    end
    rst = 1'b0;
    idle(0, 3);
    drive(0, 1'b1, 8'hC3, 1'b1, 1'b1); run_frame(0, 8'hC3, 1'b1, 1'b1, 1'b0);
    idle(0, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
